// File: rtl/axi_ad9364_pkg.sv
// Shared definitions for the AD9364 loopback pattern generator and checker:
// checker state encoding and the default two-word I/Q pattern.
package axi_ad9364_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam logic [11:0] PAT_IDATA1 = 12'o2064;
  localparam logic [11:0] PAT_QDATA1 = 12'o1753;
  localparam logic [11:0] PAT_IDATA2 = 12'o4402;
  localparam logic [11:0] PAT_QDATA2 = 12'o1337;

endpackage

// File: rtl/axi_ad9364_sat_cnt.sv
// Saturating up-counter; clear has priority over increment and the count
// holds at all-ones instead of wrapping.
module axi_ad9364_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (clr) begin
      cnt_p1 <= '0;
    end else if (inc && (cnt_p1 != {W{1'b1}})) begin
      cnt_p1 <= cnt_p1 + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_p1;

endmodule

// File: rtl/axi_ad9364_data_chk.sv
// Receive-side checker for the AD9364 alternating I/Q loopback pattern (R1 only).
// Optional chipscope bundles are built when AD9364_CHK_DBG_EN is defined.
module axi_ad9364_data_chk
  import axi_ad9364_pkg::*;
#(
  parameter logic [11:0] IDATA1       = PAT_IDATA1,
  parameter logic [11:0] QDATA1       = PAT_QDATA1,
  parameter logic [11:0] IDATA2       = PAT_IDATA2,
  parameter logic [11:0] QDATA2       = PAT_QDATA2,
  parameter int          LOCK_COUNT   = 16,
  parameter int          UNLOCK_COUNT = 4,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adc_valid,
  input  logic [11:0]          adc_data_i1,
  input  logic [11:0]          adc_data_q1,
  input  logic                 chk_clr,
  output logic                 chk_locked,
  output logic                 chk_err,
  output logic [CNT_WIDTH-1:0] chk_err_cnt,
  output logic [CNT_WIDTH-1:0] chk_sample_cnt,
  output logic [3:0]           chk_dbg_trigger,
  output logic [63:0]          chk_dbg_data
);

  localparam logic [23:0] PAT0     = {IDATA1, QDATA1};
  localparam logic [23:0] PAT1     = {IDATA2, QDATA2};
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [3:0]  UNLOCK_N = 4'(UNLOCK_COUNT);

  chk_state_t  state_p0, state_nxt;
  logic        exp_ph_p0, exp_ph_nxt;
  logic [7:0]  match_cnt_p0, match_cnt_nxt, match_inc;
  logic [3:0]  miss_cnt_p0, miss_cnt_nxt, miss_inc;
  logic [23:0] sample;
  logic        hit_p0, hit_p1, hit_exp;
  logic        err_nxt, smp_inc;
  logic        chk_err_p1, chk_locked_p1;

  assign sample    = {adc_data_i1, adc_data_q1};
  assign hit_p0    = (sample == PAT0);
  assign hit_p1    = (sample == PAT1);
  assign hit_exp   = exp_ph_p0 ? hit_p1 : hit_p0;
  assign match_inc = match_cnt_p0 + 8'd1;
  assign miss_inc  = miss_cnt_p0 + 4'd1;

  // ---- stage p0: checker state, advanced only on valid samples ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0     <= SEARCH;
      exp_ph_p0    <= 1'b0;
      match_cnt_p0 <= '0;
      miss_cnt_p0  <= '0;
    end else begin
      state_p0     <= state_nxt;
      exp_ph_p0    <= exp_ph_nxt;
      match_cnt_p0 <= match_cnt_nxt;
      miss_cnt_p0  <= miss_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_p0;
    exp_ph_nxt    = exp_ph_p0;
    match_cnt_nxt = match_cnt_p0;
    miss_cnt_nxt  = miss_cnt_p0;
    if (adc_valid) begin
      case (state_p0)
        SEARCH: begin
          if (hit_p0 || hit_p1) begin
            state_nxt     = VERIFY;
            match_cnt_nxt = 8'd1;
            exp_ph_nxt    = hit_p0;
          end
        end
        VERIFY: begin
          if (hit_exp) begin
            match_cnt_nxt = match_inc;
            exp_ph_nxt    = ~exp_ph_p0;
            if (match_inc == LOCK_N) begin
              state_nxt    = LOCKED;
              miss_cnt_nxt = '0;
            end
          end else begin
            // The offending sample is discarded, not used to re-seed SEARCH.
            state_nxt     = SEARCH;
            match_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          // Phase advances on misses too, so an isolated error keeps alignment.
          exp_ph_nxt = ~exp_ph_p0;
          if (hit_exp) begin
            miss_cnt_nxt = '0;
          end else if (miss_inc == UNLOCK_N) begin
            state_nxt     = SEARCH;
            match_cnt_nxt = '0;
            miss_cnt_nxt  = '0;
          end else begin
            miss_cnt_nxt = miss_inc;
          end
        end
        default: begin
          state_nxt     = SEARCH;
          match_cnt_nxt = '0;
          miss_cnt_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    err_nxt = 1'b0;
    smp_inc = 1'b0;
    if (adc_valid && (state_p0 == LOCKED)) begin
      smp_inc = 1'b1;
      err_nxt = ~hit_exp;
    end
  end

  // ---- stage p1: registered status outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_p1    <= 1'b0;
      chk_locked_p1 <= 1'b0;
    end else begin
      chk_err_p1    <= err_nxt;
      chk_locked_p1 <= (state_nxt == LOCKED);
    end
  end

  assign chk_err    = chk_err_p1;
  assign chk_locked = chk_locked_p1;

  axi_ad9364_sat_cnt #(
    .W (CNT_WIDTH)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (chk_clr),
    .inc (err_nxt),
    .cnt (chk_err_cnt)
  );

  axi_ad9364_sat_cnt #(
    .W (CNT_WIDTH)
  ) u_sample_cnt (
    .clk (clk),
    .rst (rst),
    .clr (chk_clr),
    .inc (smp_inc),
    .cnt (chk_sample_cnt)
  );

`ifdef AD9364_CHK_DBG_EN
  function automatic logic [15:0] fit16(input logic [CNT_WIDTH-1:0] v);
    return 16'(v);
  endfunction

  logic [3:0]  dbg_trigger_p1;
  logic [63:0] dbg_data_p1;

  // ---- stage p1: chipscope bundles, aligned with the status outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_trigger_p1 <= '0;
      dbg_data_p1    <= '0;
    end else begin
      dbg_trigger_p1 <= {adc_valid, err_nxt, (state_nxt == LOCKED), exp_ph_nxt};
      dbg_data_p1    <= {state_nxt, miss_cnt_nxt, match_cnt_nxt, 2'b00, sample,
                         fit16(chk_err_cnt), 8'h00};
    end
  end

  assign chk_dbg_trigger = dbg_trigger_p1;
  assign chk_dbg_data    = dbg_data_p1;
`else
  assign chk_dbg_trigger = '0;
  assign chk_dbg_data    = '0;
`endif

endmodule

// File: tb/tb_axi_ad9364_data_chk.sv
// Self-checking bench for axi_ad9364_data_chk: reference model feeds a scoreboard,
// plus directed checks on lock timing, error handling, saturation, clear and reset.
module tb_axi_ad9364_data_chk;

  localparam logic [11:0] I1 = 12'o2064;
  localparam logic [11:0] Q1 = 12'o1753;
  localparam logic [11:0] I2 = 12'o4402;
  localparam logic [11:0] Q2 = 12'o1337;
  localparam logic [11:0] ONES = 12'o7777;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_valid;
  logic [11:0] adc_data_i1;
  logic [11:0] adc_data_q1;
  logic        chk_clr;

  logic        chk_locked, chk_err;
  logic [15:0] chk_err_cnt, chk_sample_cnt;
  logic [3:0]  chk_dbg_trigger;
  logic [63:0] chk_dbg_data;

  logic        locked4, err4;
  logic [3:0]  err_cnt4, smp_cnt4;
  logic [3:0]  trig4;
  logic [63:0] data4;

  always #5 clk = ~clk;

  axi_ad9364_data_chk dut (
    .clk             (clk),
    .rst             (rst),
    .adc_valid       (adc_valid),
    .adc_data_i1     (adc_data_i1),
    .adc_data_q1     (adc_data_q1),
    .chk_clr         (chk_clr),
    .chk_locked      (chk_locked),
    .chk_err         (chk_err),
    .chk_err_cnt     (chk_err_cnt),
    .chk_sample_cnt  (chk_sample_cnt),
    .chk_dbg_trigger (chk_dbg_trigger),
    .chk_dbg_data    (chk_dbg_data)
  );

  axi_ad9364_data_chk #(.CNT_WIDTH(4)) dut4 (
    .clk             (clk),
    .rst             (rst),
    .adc_valid       (adc_valid),
    .adc_data_i1     (adc_data_i1),
    .adc_data_q1     (adc_data_q1),
    .chk_clr         (chk_clr),
    .chk_locked      (locked4),
    .chk_err         (err4),
    .chk_err_cnt     (err_cnt4),
    .chk_sample_cnt  (smp_cnt4),
    .chk_dbg_trigger (trig4),
    .chk_dbg_data    (data4)
  );

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] ecnt;
    logic [15:0] scnt;
    logic [3:0]  ecnt4;
    logic [3:0]  scnt4;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int m_state = 0;
  int m_match = 0;
  int m_miss  = 0;
  bit m_ph    = 1'b0;
  int m_ecnt = 0, m_scnt = 0, m_ecnt4 = 0, m_scnt4 = 0;

  task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic model_step(input bit v, input logic [23:0] s, input bit c, input bit r,
                            output exp_t e);
    bit err = 1'b0;
    bit inc_s = 1'b0;
    logic [23:0] pexp;
    if (r) begin
      m_state = 0; m_match = 0; m_miss = 0; m_ph = 1'b0;
      m_ecnt = 0; m_scnt = 0; m_ecnt4 = 0; m_scnt4 = 0;
    end else begin
      pexp = m_ph ? {I2, Q2} : {I1, Q1};
      if (v) begin
        if (m_state == 0) begin
          if (s == {I1, Q1}) begin m_state = 1; m_match = 1; m_ph = 1'b1; end
          else if (s == {I2, Q2}) begin m_state = 1; m_match = 1; m_ph = 1'b0; end
        end else if (m_state == 1) begin
          if (s == pexp) begin
            m_match++;
            m_ph = !m_ph;
            if (m_match == 16) begin m_state = 2; m_miss = 0; end
          end else begin
            m_state = 0; m_match = 0;
          end
        end else begin
          inc_s = 1'b1;
          m_ph = !m_ph;
          if (s == pexp) m_miss = 0;
          else begin
            err = 1'b1;
            m_miss++;
            if (m_miss == 4) begin m_state = 0; m_match = 0; m_miss = 0; end
          end
        end
      end
      if (c) begin
        m_ecnt = 0; m_scnt = 0; m_ecnt4 = 0; m_scnt4 = 0;
      end else begin
        if (err) begin
          if (m_ecnt < 65535) m_ecnt++;
          if (m_ecnt4 < 15) m_ecnt4++;
        end
        if (inc_s) begin
          if (m_scnt < 65535) m_scnt++;
          if (m_scnt4 < 15) m_scnt4++;
        end
      end
    end
    e.locked = (m_state == 2);
    e.err    = err;
    e.ecnt   = 16'(m_ecnt);
    e.scnt   = 16'(m_scnt);
    e.ecnt4  = 4'(m_ecnt4);
    e.scnt4  = 4'(m_scnt4);
  endtask

  task automatic step(input bit v, input logic [11:0] i, input logic [11:0] q,
                      input bit c, input bit r);
    exp_t e;
    rst = r; adc_valid = v; adc_data_i1 = i; adc_data_q1 = q; chk_clr = c;
    model_step(v, {i, q}, c, r, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp("sb_locked",  64'(chk_locked),     64'(e.locked));
    cmp("sb_err",     64'(chk_err),        64'(e.err));
    cmp("sb_err_cnt", 64'(chk_err_cnt),    64'(e.ecnt));
    cmp("sb_smp_cnt", 64'(chk_sample_cnt), 64'(e.scnt));
    cmp("sb_locked4", 64'(locked4),        64'(e.locked));
    cmp("sb_err_cnt4", 64'(err_cnt4),      64'(e.ecnt4));
    cmp("sb_smp_cnt4", 64'(smp_cnt4),      64'(e.scnt4));
  endtask

  task automatic good();
    step(1'b1, m_ph ? I2 : I1, m_ph ? Q2 : Q1, 1'b0, 1'b0);
  endtask

  task automatic bad();
    step(1'b1, ONES, ONES, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; adc_valid = 1'b0; chk_clr = 1'b0; adc_data_i1 = '0; adc_data_q1 = '0;
    repeat (3) step(1'b0, 12'o0, 12'o0, 1'b0, 1'b1);
    cmp("rst_locked",  64'(chk_locked), 64'd0);
    cmp("rst_err",     64'(chk_err), 64'd0);
    cmp("rst_err_cnt", 64'(chk_err_cnt), 64'd0);
    cmp("rst_smp_cnt", 64'(chk_sample_cnt), 64'd0);
    cmp("rst_trig",    64'(chk_dbg_trigger), 64'd0);
    cmp("rst_data",    chk_dbg_data, 64'd0);

    // clean stream, valid held high
    for (int k = 1; k <= 16; k++) begin
      good();
      if (k == 15) cmp("t1_prelock", 64'(chk_locked), 64'd0);
    end
    cmp("t1_lock", 64'(chk_locked), 64'd1);
    cmp("t1_smp0", 64'(chk_sample_cnt), 64'd0);
    repeat (100) good();
    cmp("t1_smp100", 64'(chk_sample_cnt), 64'd100);
    cmp("t1_err0",   64'(chk_err_cnt), 64'd0);

    // single corrupted I word
    step(1'b1, 12'o0000, m_ph ? Q2 : Q1, 1'b0, 1'b0);
    cmp("t3_err_pulse", 64'(chk_err), 64'd1);
    cmp("t3_err_cnt",   64'(chk_err_cnt), 64'd1);
    cmp("t3_locked",    64'(chk_locked), 64'd1);
    good();
    cmp("t3_next_ok",   64'(chk_err), 64'd0);
    cmp("t3_cnt_hold",  64'(chk_err_cnt), 64'd1);

    // four consecutive all-ones samples drop lock
    step(1'b0, 12'o0, 12'o0, 1'b1, 1'b0);
    cmp("t4_clr", 64'(chk_err_cnt), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      bad();
      if (k == 3) cmp("t4_still_locked", 64'(chk_locked), 64'd1);
    end
    cmp("t4_err_cnt", 64'(chk_err_cnt), 64'd4);
    cmp("t4_unlock",  64'(chk_locked), 64'd0);
    for (int k = 1; k <= 16; k++) begin
      good();
      if (k == 15) cmp("t4_prerelock", 64'(chk_locked), 64'd0);
    end
    cmp("t4_relock", 64'(chk_locked), 64'd1);

    // sustained alternating errors keep lock and saturate the 4-bit counter
    step(1'b0, 12'o0, 12'o0, 1'b1, 1'b0);
    repeat (20) begin
      good();
      bad();
    end
    cmp("t6_err_cnt16", 64'(chk_err_cnt), 64'd20);
    cmp("t6_err_cnt4",  64'(err_cnt4), 64'd15);
    cmp("t6_locked",    64'(chk_locked), 64'd1);

    // clear coincident with an error
    step(1'b1, ONES, ONES, 1'b1, 1'b0);
    cmp("t7_err_pulse", 64'(chk_err), 64'd1);
    cmp("t7_err_cnt",   64'(chk_err_cnt), 64'd0);
    cmp("t7_smp_cnt",   64'(chk_sample_cnt), 64'd0);
    cmp("t7_locked",    64'(chk_locked), 64'd1);

    // reset while locked
    step(1'b1, m_ph ? I2 : I1, m_ph ? Q2 : Q1, 1'b0, 1'b1);
    cmp("t8_locked", 64'(chk_locked), 64'd0);
    cmp("t8_err",    64'(chk_err), 64'd0);
    cmp("t8_trig",   64'(chk_dbg_trigger), 64'd0);
    cmp("t8_data",   chk_dbg_data, 64'd0);

    // mismatch at the 10th sample of VERIFY
    for (int k = 1; k <= 9; k++) good();
    bad();
    cmp("t5_locked",  64'(chk_locked), 64'd0);
    cmp("t5_err",     64'(chk_err), 64'd0);
    cmp("t5_err_cnt", 64'(chk_err_cnt), 64'd0);
    for (int k = 1; k <= 16; k++) begin
      good();
      if (k == 15) cmp("t5_prelock", 64'(chk_locked), 64'd0);
    end
    cmp("t5_lock", 64'(chk_locked), 64'd1);

    // generator cadence: valid every other cycle, first word P1
    step(1'b0, 12'o0, 12'o0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k % 2 == 0) ? I2 : I1, (k % 2 == 0) ? Q2 : Q1, 1'b0, 1'b0);
      if (k == 14) cmp("t2_prelock", 64'(chk_locked), 64'd0);
      if (k == 15) cmp("t2_lock", 64'(chk_locked), 64'd1);
      step(1'b0, 12'($urandom), 12'($urandom), 1'b0, 1'b0);
    end
    step(1'b1, I2, Q2, 1'b0, 1'b0);
    cmp("t2_phase_err", 64'(chk_err), 64'd0);
    cmp("t2_err_cnt",   64'(chk_err_cnt), 64'd0);
    cmp("t2_smp_cnt",   64'(chk_sample_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
